// File: rtl/mem_copy_master.sv
// Copies LEN bytes SRC->DST through one arbiter port, one read then one write per byte.
// Latency: first request the cycle after start; back-to-back requests; done/err one cycle after FIN/ABORT entry.
// Backpressure: each request holds until acq; TIMEOUT cycles without acq aborts the copy.
module mem_copy_master #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_src_addr,
  input  logic [AW-1:0] i_dst_addr,
  input  logic [7:0]    i_len,
  output logic          o_rden,
  output logic          o_wren,
  output logic [AW-1:0] o_address,
  output logic [DW-1:0] o_din,
  input  logic          i_acq,
  input  logic [DW-1:0] i_dq,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [7:0]    o_xfer_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_WR_REQ,
    S_FIN,
    S_ABORT
  } state_t;

  // Last wait-counter value before a request is declared dead.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_src, w_src_nxt;
  logic [AW-1:0] r_dst, w_dst_nxt;
  logic [AW-1:0] r_address, w_address_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic [7:0]    r_rem, w_rem_nxt;
  logic [7:0]    r_xfer_cnt, w_xfer_cnt_nxt;
  logic [7:0]    r_wait, w_wait_nxt;
  logic          r_rden, w_rden_nxt;
  logic          r_wren, w_wren_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  // State and every output register; reset forces all to zero / IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_address  <= '0;
      r_din      <= '0;
      r_rem      <= '0;
      r_xfer_cnt <= '0;
      r_wait     <= '0;
      r_rden     <= 1'b0;
      r_wren     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_dst      <= w_dst_nxt;
      r_address  <= w_address_nxt;
      r_din      <= w_din_nxt;
      r_rem      <= w_rem_nxt;
      r_xfer_cnt <= w_xfer_cnt_nxt;
      r_wait     <= w_wait_nxt;
      r_rden     <= w_rden_nxt;
      r_wren     <= w_wren_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state and next-output computation; registers hold unless a state acts on them.
  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_dst_nxt      = r_dst;
    w_address_nxt  = r_address;
    w_din_nxt      = r_din;
    w_rem_nxt      = r_rem;
    w_xfer_cnt_nxt = r_xfer_cnt;
    w_wait_nxt     = r_wait;
    w_rden_nxt     = r_rden;
    w_wren_nxt     = r_wren;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_src_nxt      = i_src_addr;
          w_dst_nxt      = i_dst_addr;
          w_rem_nxt      = i_len;
          w_xfer_cnt_nxt = '0;
          w_wait_nxt     = '0;
          w_busy_nxt     = 1'b1;
          if (i_len == 8'd0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt   = S_RD_REQ;
            w_rden_nxt    = 1'b1;
            w_address_nxt = i_src_addr;
          end
        end
      end

      S_RD_REQ: begin
        if (i_acq) begin
          w_din_nxt     = i_dq;
          w_rden_nxt    = 1'b0;
          w_wren_nxt    = 1'b1;
          w_address_nxt = r_dst;
          w_src_nxt     = r_src + AW'(1);
          w_wait_nxt    = '0;
          w_state_nxt   = S_WR_REQ;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_rden_nxt  = 1'b0;
          w_state_nxt = S_ABORT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_WR_REQ: begin
        if (i_acq) begin
          w_wren_nxt     = 1'b0;
          w_dst_nxt      = r_dst + AW'(1);
          w_rem_nxt      = r_rem - 8'd1;
          w_xfer_cnt_nxt = r_xfer_cnt + 8'd1;
          w_wait_nxt     = '0;
          if (r_rem == 8'd1) begin
            w_state_nxt = S_FIN;
          end else begin
            // src was already advanced when the read completed.
            w_rden_nxt    = 1'b1;
            w_address_nxt = r_src;
            w_state_nxt   = S_RD_REQ;
          end
        end else if (r_wait == LP_WAIT_LAST) begin
          w_wren_nxt  = 1'b0;
          w_state_nxt = S_ABORT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end

      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      S_ABORT: begin
        w_err_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_rden_nxt  = 1'b0;
        w_wren_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_rden     = r_rden;
  assign o_wren     = r_wren;
  assign o_address  = r_address;
  assign o_din      = r_din;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: behavioural arbiter+RAM, expected-event queue, negedge monitor.
// Expected reads/writes/done/err are queued before each start and popped as the DUT presents them.
// Arbiter grant delay and write withholding are programmable per test.
module tb_mem_copy_master;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_src_addr;
  logic [7:0] i_dst_addr;
  logic [7:0] i_len;
  logic       o_rden;
  logic       o_wren;
  logic [7:0] o_address;
  logic [7:0] o_din;
  logic       i_acq;
  logic [7:0] i_dq;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [7:0] o_xfer_cnt;

  mem_copy_master #(.AW(8), .DW(8), .TIMEOUT(8)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_src_addr (i_src_addr),
    .i_dst_addr (i_dst_addr),
    .i_len      (i_len),
    .o_rden     (o_rden),
    .o_wren     (o_wren),
    .o_address  (o_address),
    .o_din      (o_din),
    .i_acq      (i_acq),
    .i_dq       (i_dq),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_xfer_cnt (o_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 read, 1 write, 2 done, 3 err; data holds xfer_cnt for done/err
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         dly_min  = 0;
  int         dly_max  = 0;
  int         wr_budget = 1000;
  int         acq_count = 0;
  int         excl_bad  = 0;
  int         wr_run    = 0;
  int         wr_run_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic start_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
    @(negedge clk);
    i_start    = 1'b1;
    i_src_addr = src;
    i_dst_addr = dst;
    i_len      = len;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < max_cyc) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && !o_busy)}, 32'd1);
  endtask

  // Arbiter + RAM model: grants after a programmable delay, may withhold writes.
  initial begin
    int  cnt;
    bit  pend;
    pend  = 0;
    cnt   = 0;
    i_acq = 1'b0;
    i_dq  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      i_acq = 1'b0;
      if (i_rst || !(o_rden || o_wren)) begin
        pend = 0;
      end else if (o_wren && wr_budget <= 0) begin
        pend = 0;
      end else begin
        if (!pend) begin
          pend = 1;
          cnt  = int'($urandom_range(dly_max, dly_min));
        end
        if (cnt == 0) begin
          i_acq = 1'b1;
          pend  = 0;
          acq_count++;
          if (o_rden) begin
            i_dq = mem[o_address];
          end else begin
            mem[o_address] = o_din;
            wr_budget--;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic pop_cmp(input int kind, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == kind) begin
        if (kind < 2) check("event_addr", {24'd0, addr}, {24'd0, e.addr});
        check("event_data", {24'd0, data}, {24'd0, e.data});
      end
    end
  endtask

  // Monitor: pops one expected event per observed read/write grant, done or err.
  initial begin
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (o_rden && o_wren) excl_bad++;
        if (o_wren && !i_acq) wr_run++;
        else wr_run = 0;
        if (wr_run > wr_run_max) wr_run_max = wr_run;
        if (i_acq && o_rden) pop_cmp(0, o_address, i_dq);
        if (i_acq && o_wren) pop_cmp(1, o_address, o_din);
        if (o_done) begin
          pop_cmp(2, 8'h00, o_xfer_cnt);
          check("done_busy_low", {31'd0, o_busy}, 32'd0);
        end
        if (o_err) begin
          pop_cmp(3, 8'h00, o_xfer_cnt);
          check("err_req_low", {30'd0, o_rden, o_wren}, 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic check_all_zero(input string name);
    check(name, {o_rden, o_wren, o_address, o_din, o_busy, o_done, o_err, o_xfer_cnt},
          32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    i_rst = 1'b1; i_start = 1'b0; i_src_addr = 8'h00; i_dst_addr = 8'h00; i_len = 8'h00;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    mem[8'h30] = 8'h5A; mem[8'h31] = 8'h6B; mem[8'h32] = 8'h7C;
    mem[8'h70] = 8'h0F; mem[8'h71] = 8'hF0;
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h03; mem[8'h43] = 8'h04;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    i_rst = 1'b0;

    // Test 1: basic 3-byte copy, grant one cycle into each request
    dly_min = 1; dly_max = 1; acq_count = 0;
    push(0, 8'h10, 8'hA1); push(1, 8'h20, 8'hA1);
    push(0, 8'h11, 8'hB2); push(1, 8'h21, 8'hB2);
    push(0, 8'h12, 8'hC3); push(1, 8'h22, 8'hC3);
    push(2, 8'h00, 8'd3);
    start_copy(8'h10, 8'h20, 8'd3);
    wait_end("t1_end", 100);
    check("t1_ram", {8'h00, mem[8'h20], mem[8'h21], mem[8'h22]}, 32'h00A1B2C3);
    check("t1_acq_count", acq_count, 32'd6);
    check("t1_xfer_cnt", {24'd0, o_xfer_cnt}, 32'd3);

    // Test 2: len=0, done two cycles after start, no accesses
    dly_min = 0; dly_max = 0; acq_count = 0;
    push(2, 8'h00, 8'd0);
    @(negedge clk);
    i_start = 1'b1; i_src_addr = 8'h10; i_dst_addr = 8'h20; i_len = 8'd0;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    check("t2_busy_c1", {30'd0, o_busy, o_done}, 32'd2);
    @(negedge clk);
    #1;
    check("t2_done_c2", {30'd0, o_busy, o_done}, 32'd1);
    wait_end("t2_end", 20);
    check("t2_no_acq", acq_count, 32'd0);

    // Test 3: address wrap FE,FF,00 -> 7E,7F,80
    push(0, 8'hFE, 8'h11); push(1, 8'h7E, 8'h11);
    push(0, 8'hFF, 8'h22); push(1, 8'h7F, 8'h22);
    push(0, 8'h00, 8'h33); push(1, 8'h80, 8'h33);
    push(2, 8'h00, 8'd3);
    start_copy(8'hFE, 8'h7E, 8'd3);
    wait_end("t3_end", 100);
    check("t3_ram", {8'h00, mem[8'h7E], mem[8'h7F], mem[8'h80]}, 32'h00112233);

    // Test 4: second write never granted -> abort after 8 wait cycles
    wr_budget = 1; wr_run_max = 0;
    push(0, 8'h30, 8'h5A); push(1, 8'h50, 8'h5A);
    push(0, 8'h31, 8'h6B);
    push(3, 8'h00, 8'd1);
    start_copy(8'h30, 8'h50, 8'd3);
    wait_end("t4_end", 100);
    check("t4_wait_cycles", wr_run_max, 32'd8);
    check("t4_xfer_cnt", {24'd0, o_xfer_cnt}, 32'd1);
    check("t4_ram_untouched", {24'd0, mem[8'h51]}, 32'd0);
    wr_budget = 1000;

    // Test 5: reset while a write is pending, then restart
    wr_budget = 0;
    push(0, 8'h70, 8'h0F);
    start_copy(8'h70, 8'h90, 8'd2);
    begin
      int k;
      k = 0;
      while (!o_wren && k < 30) begin
        @(negedge clk);
        k++;
      end
      check("t5_reached_wr", {31'd0, o_wren}, 32'd1);
    end
    i_rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("t5_reset_outputs");
    i_rst = 1'b0;
    check("t5_queue_drained", exp_q.size(), 32'd0);
    wr_budget = 1000;
    push(0, 8'h70, 8'h0F); push(1, 8'h90, 8'h0F);
    push(0, 8'h71, 8'hF0); push(1, 8'h91, 8'hF0);
    push(2, 8'h00, 8'd2);
    start_copy(8'h70, 8'h90, 8'd2);
    wait_end("t5_end", 100);
    check("t5_ram", {16'h0000, mem[8'h90], mem[8'h91]}, 32'h00000FF0);

    // Test 6: start re-pulsed while busy, random grant delays 0..5
    dly_min = 0; dly_max = 5; excl_bad = 0;
    push(0, 8'h40, 8'h01); push(1, 8'h60, 8'h01);
    push(0, 8'h41, 8'h02); push(1, 8'h61, 8'h02);
    push(0, 8'h42, 8'h03); push(1, 8'h62, 8'h03);
    push(0, 8'h43, 8'h04); push(1, 8'h63, 8'h04);
    push(2, 8'h00, 8'd4);
    start_copy(8'h40, 8'h60, 8'd4);
    repeat (3) @(negedge clk);
    start_copy(8'h00, 8'h00, 8'd5);
    wait_end("t6_end", 300);
    check("t6_ram", {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]}, 32'h01020304);
    check("t6_xfer_cnt", {24'd0, o_xfer_cnt}, 32'd4);
    repeat (5) @(negedge clk);
    #1;
    check("t6_idle_after", {30'd0, o_busy, o_rden | o_wren}, 32'd0);
    check("rden_wren_exclusive", excl_bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
